// File: rtl/parity_serializer.sv
// parity_serializer: start + 6 word bits (LSB first) + stop serial framer.
// Define PARITY_CHECK_EN to drop odd-parity words and pulse par_err instead.
module parity_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_word,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [5:0]    shift, shift_n;
  logic          tx_n, busy_n, done_n;
  logic          tick;
  logic          bad;

  assign in_ready = (state == IDLE);
  assign tick     = (cnt == CMAX);

`ifdef PARITY_CHECK_EN
  logic perr_q;

  assign bad     = ^in_word;
  assign par_err = perr_q;

  // One-cycle error pulse for a word rejected at accept.
  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= in_ready & in_valid & bad;
  end
`else
  assign bad     = 1'b0;
  assign par_err = 1'b0;
`endif

  // State, datapath and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shift  <= shift_n;
      tx_out <= tx_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next state; line outputs are computed one cycle ahead so they register cleanly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx_out;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (in_valid && !bad) begin
          state_n = START;
          shift_n = in_word;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          cnt_n   = '0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n = '0;
          if (idx == 3'd5) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = shift >> 1;
            idx_n   = idx + 3'd1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: directed checks of the serial framer.
// Instances with 4 and 2 clocks per bit share clock and reset.
module tb_parity_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] w4, w2;
  logic       v4, v2;
  logic       r4, t4, b4, d4, p4;
  logic       r2, t2, b2, d2, p2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  parity_serializer #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .in_word(w4), .in_valid(v4),
    .in_ready(r4), .tx_out(t4), .busy(b4), .done(d4),
    .par_err(p4)
  );

  parity_serializer #(.CLKS_PER_BIT(2)) u2 (
    .clk(clk), .rst(rst), .in_word(w2), .in_valid(v2),
    .in_ready(r2), .tx_out(t2), .busy(b2), .done(d2),
    .par_err(p2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v4 = 1'b0; v2 = 1'b0;
    w4 = '0; w2 = '0;
    step(); step();
    checks++;
    if ({t4, b4, r4, d4, p4} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_c4: got %b expected 10100",
               {t4, b4, r4, d4, p4});
    end
    checks++;
    if ({t2, b2, r2, d2, p2} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_c2: got %b expected 10100",
               {t2, b2, r2, d2, p2});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({t4, b4, r4, d4, p4} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 10100",
               {t4, b4, r4, d4, p4});
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] f;
    logic [3:0] e;
    f = 8'b1101_1010;
    w4 = 6'b101101; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      e = {f[(j-1)/4], 3'b100};
      checks++;
      if ({t4, b4, r4, d4} !== e) begin
        errors++;
        $display("FAIL single cyc %0d: got %b expected %b",
                 j, {t4, b4, r4, d4}, e);
      end
      step();
    end
    checks++;
    if ({t4, b4, r4, d4} !== 4'b1011) begin
      errors++;
      $display("FAIL single done: got %b expected 1011",
               {t4, b4, r4, d4});
    end
    step();
    checks++;
    if ({t4, b4, r4, d4} !== 4'b1010) begin
      errors++;
      $display("FAIL single after: got %b expected 1010",
               {t4, b4, r4, d4});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1, f2;
    logic [3:0] e;
    f1 = 8'b1101_1010;
    f2 = 8'b1110_0110;
    w4 = 6'b101101; v4 = 1'b1;
    step();
    for (int j = 1; j <= 32; j++) begin
      e = {f1[(j-1)/4], 3'b100};
      checks++;
      if ({t4, b4, r4, d4} !== e) begin
        errors++;
        $display("FAIL b2b f1 cyc %0d: got %b expected %b",
                 j, {t4, b4, r4, d4}, e);
      end
      if (j == 32) w4 = 6'b110011;
      step();
    end
    checks++;
    if ({t4, b4, r4, d4} !== 4'b1011) begin
      errors++;
      $display("FAIL b2b gap: got %b expected 1011",
               {t4, b4, r4, d4});
    end
    step();
    v4 = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      e = {f2[(j-1)/4], 3'b100};
      checks++;
      if ({t4, b4, r4, d4} !== e) begin
        errors++;
        $display("FAIL b2b f2 cyc %0d: got %b expected %b",
                 j, {t4, b4, r4, d4}, e);
      end
      step();
    end
    checks++;
    if ({t4, b4, r4, d4} !== 4'b1011) begin
      errors++;
      $display("FAIL b2b done2: got %b expected 1011",
               {t4, b4, r4, d4});
    end
    step();
  endtask

  task automatic test_busy_ignore();
    logic [7:0] f;
    logic [3:0] e;
    f = 8'b1101_1010;
    w4 = 6'b101101; v4 = 1'b1;
    step();
    for (int j = 1; j <= 32; j++) begin
      e = {f[(j-1)/4], 3'b100};
      checks++;
      if ({t4, b4, r4, d4} !== e) begin
        errors++;
        $display("FAIL ignore cyc %0d: got %b expected %b",
                 j, {t4, b4, r4, d4}, e);
      end
      v4 = (j == 32) ? 1'b0 : 1'($urandom_range(0, 1));
      w4 = 6'($urandom);
      step();
    end
    checks++;
    if ({t4, b4, r4, d4} !== 4'b1011) begin
      errors++;
      $display("FAIL ignore done: got %b expected 1011",
               {t4, b4, r4, d4});
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    w4 = 6'b101101; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int j = 1; j < 10; j++) step();
    checks++;
    if ({t4, b4} !== 2'b01) begin
      errors++;
      $display("FAIL midrst bit1: got %b expected 01", {t4, b4});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      checks++;
      if ({t4, b4, r4, d4} !== 4'b1010) begin
        errors++;
        $display("FAIL midrst cyc %0d: got %b expected 1010",
                 j + 11, {t4, b4, r4, d4});
      end
      step();
    end
  endtask

  task automatic test_parity_screen();
    w4 = 6'b000001; v4 = 1'b1;
    step();
    v4 = 1'b0;
`ifdef PARITY_CHECK_EN
    checks++;
    if ({t4, b4, r4, d4, p4} !== 5'b10101) begin
      errors++;
      $display("FAIL parity pulse: got %b expected 10101",
               {t4, b4, r4, d4, p4});
    end
    step();
    for (int j = 2; j <= 10; j++) begin
      checks++;
      if ({t4, b4, r4, d4, p4} !== 5'b10100) begin
        errors++;
        $display("FAIL parity idle cyc %0d: got %b expected 10100",
                 j, {t4, b4, r4, d4, p4});
      end
      step();
    end
`else
    begin
      logic [7:0] f;
      logic [4:0] e;
      f = 8'b1000_0010;
      for (int j = 1; j <= 32; j++) begin
        e = {f[(j-1)/4], 4'b1000};
        checks++;
        if ({t4, b4, r4, d4, p4} !== e) begin
          errors++;
          $display("FAIL parity frame cyc %0d: got %b expected %b",
                   j, {t4, b4, r4, d4, p4}, e);
        end
        step();
      end
      checks++;
      if ({t4, b4, r4, d4, p4} !== 5'b10110) begin
        errors++;
        $display("FAIL parity done: got %b expected 10110",
                 {t4, b4, r4, d4, p4});
      end
      step();
    end
`endif
  endtask

  task automatic test_min_divider();
    w2 = 6'b011010; v2 = 1'b1;
    step();
    v2 = 1'b0;
`ifdef PARITY_CHECK_EN
    checks++;
    if ({t2, b2, r2, d2, p2} !== 5'b10101) begin
      errors++;
      $display("FAIL min_div reject: got %b expected 10101",
               {t2, b2, r2, d2, p2});
    end
    step();
`else
    begin
      logic [7:0] f;
      logic [3:0] e;
      f = 8'b1011_0100;
      for (int j = 1; j <= 16; j++) begin
        e = {f[(j-1)/2], 3'b100};
        checks++;
        if ({t2, b2, r2, d2} !== e) begin
          errors++;
          $display("FAIL min_div cyc %0d: got %b expected %b",
                   j, {t2, b2, r2, d2}, e);
        end
        step();
      end
      checks++;
      if ({t2, b2, r2, d2} !== 4'b1011) begin
        errors++;
        $display("FAIL min_div done: got %b expected 1011",
                 {t2, b2, r2, d2});
      end
      step();
      checks++;
      if ({t2, b2, r2, d2} !== 4'b1010) begin
        errors++;
        $display("FAIL min_div after: got %b expected 1010",
                 {t2, b2, r2, d2});
      end
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_parity_screen();
    test_min_divider();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_serializer.md
# parity_serializer

Downstream stage of the 5-bit even-parity generator. Accepts a 6-bit parity word (`[5:1]` data, `[0]` parity bit) through a valid/ready handshake and shifts it out on a single line as an asynchronous-style frame: start bit, 6 word bits LSB first, stop bit. Bit time is a parameterised number of clock cycles. Optionally screens words for parity errors before transmission.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `in_word`  in  6  word to send; sampled only on accept.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `tx_out`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line (START/DATA/STOP).
- `done`  out  1  one-cycle pulse after the stop bit completes.
- `par_err`  out  1  one-cycle pulse on a rejected word; constant 0 when the checking feature is compiled out.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Accept: `in_valid & in_ready` at a rising edge. The block captures `in_word` into the shift register and moves IDLE→START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then →DATA.
- DATA: `tx_out`=shift[0]. Every `CLKS_PER_BIT` cycles the register shifts right and the bit index increments 0..5. After bit 5 completes, →STOP.
- STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles, then →IDLE with `done`=1 for that one IDLE cycle.
- Baud counter: runs 0..`CLKS_PER_BIT`-1, clears on every state change, and has width `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits.
- `in_valid` is ignored outside IDLE, and `in_word` changes while busy have no effect.
- `tx_out`, `busy` and `done` are registered outputs. `in_ready` = (state==IDLE).
- Reset values: state IDLE, `tx_out`=1, `busy`=0, `done`=0, `par_err`=0, `in_ready`=1, shift register 0, counters 0.
- Reset mid-frame aborts immediately. `tx_out` returns to 1 on the cycle after the reset edge. No `done` is generated.

## Timing
- Accept at edge T0.
- Start bit occupies cycles T0+1 .. T0+C, where C=`CLKS_PER_BIT`.
- Word bit i occupies T0+1+(i+1)C .. T0+(i+2)C.
- Stop bit occupies T0+1+7C .. T0+8C.
- `busy`=1 for cycles T0+1 .. T0+8C.
- `done`=1 and `in_ready`=1 in cycle T0+8C+1.
- Back-to-back transfer: a word presented in the `done` cycle is accepted there. Its start bit begins one cycle later, giving an inter-frame gap of exactly one high cycle.
- Frame length is 8C cycles. Throughput is one word per 8C+1 cycles.

## Configuration
- `PARITY_CHECK_EN` defined:
  - On accept, the block computes the XOR of all 6 bits of `in_word`.
  - If the result is 1 (odd, a bad word), the word is dropped. The block stays in IDLE, `tx_out` stays 1, and `par_err`=1 for the next cycle only.
  - Good words are transmitted normally.
- `PARITY_CHECK_EN` undefined:
  - No check is made and every accepted word is transmitted.
  - `par_err` is tied to 0.

## Test plan
All scenarios use C=4.
- **Single frame:** reset, then send `in_word`=6'b101101. `tx_out` carries 0,1,0,1,1,0,1,1, each level held for 4 cycles. `done` pulses at T0+33. `busy` is high for cycles T0+1..T0+32.
- **Back-to-back:** hold `in_valid` high with 6'b101101 then 6'b110011. The second accept occurs at T0+33 and its start bit begins at T0+34. Exactly one high cycle separates the frames.
- **Busy ignore:** toggle `in_valid` with random words during a frame. `in_ready`=0 throughout, and the transmitted frame is unchanged.
- **Reset mid-frame:** assert `rst` at T0+10 (inside bit 1). At T0+11, `tx_out`=1, `busy`=0, `in_ready`=1, and no `done` pulse occurs.
- **Parity screen:** send 6'b000001.
  - With `PARITY_CHECK_EN`: `par_err`=1 for one cycle at T0+1, `tx_out` stays 1, and `in_ready` stays 1.
  - Without it: the frame 0,1,0,0,0,0,0,1 is transmitted and `par_err` stays 0.
- **Minimum divider:** C=2 with word 6'b011010. Each bit is held for 2 cycles and `done` pulses at T0+17.
